// File: rtl/id_ex_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : id_ex_stage
// Description : ID/EX pipeline stage. It registers one decoded ALU op per
//               cycle and presents ctrl/in_1/in_2 to the combinational ALU.
//               Valid/ready handshakes are used on both sides. A MAIN+SKID
//               pair of slots keeps full throughput under backpressure.
//               Optional writeback bypass is enabled by defining FORWARD_EN.
//               ctrl is passed through unchanged; its encoding belongs to the
//               ALU (`AND/`OR/`ADD/`SUB).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module id_ex_stage #(
    parameter int DATA_W = `DATA_SIZE,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ctrl,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_rd_we,
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_rd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_rd_we
);

    // Payload of one held op; op2 already reflects the imm/rs2 selection.
    typedef struct packed {
        logic [1:0]        ctrl;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic              use_imm;
        logic [REG_AW-1:0] rd;
        logic              we;
    } slot_t;

    logic  r_main_valid;
    logic  r_skid_valid;
    slot_t r_main;
    slot_t r_skid;

    slot_t w_in_slot;
    slot_t w_in_fwd;
    slot_t w_main_fwd;
    slot_t w_skid_fwd;
    logic  w_accept;
    logic  w_consume;

    assign in_ready  = !r_skid_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // Pack the incoming op, selecting the immediate or rs2 as the second operand.
    always_comb begin
        w_in_slot         = '0;
        w_in_slot.ctrl    = in_ctrl;
        w_in_slot.rs1     = in_rs1_addr;
        w_in_slot.rs2     = in_rs2_addr;
        w_in_slot.op1     = in_rs1_data;
        w_in_slot.op2     = in_use_imm ? in_imm : in_rs2_data;
        w_in_slot.use_imm = in_use_imm;
        w_in_slot.rd      = in_rd_addr;
        w_in_slot.we      = in_rd_we;
    end

`ifdef FORWARD_EN
    logic w_fwd_live;

    // x0 is hardwired to zero, so a write to it must never be bypassed.
    assign w_fwd_live = fwd_valid && (fwd_rd_addr != '0);

    // Replace operands whose source register is being written back this cycle.
    function automatic slot_t f_bypass(input slot_t s, input logic live,
                                       input logic [REG_AW-1:0] addr,
                                       input logic [DATA_W-1:0] data);
        slot_t r;
        r = s;
        if (live && (s.rs1 == addr))
            r.op1 = data;
        if (live && !s.use_imm && (s.rs2 == addr))
            r.op2 = data;
        return r;
    endfunction

    assign w_in_fwd   = f_bypass(w_in_slot, w_fwd_live, fwd_rd_addr, fwd_data);
    assign w_main_fwd = f_bypass(r_main,    w_fwd_live, fwd_rd_addr, fwd_data);
    assign w_skid_fwd = f_bypass(r_skid,    w_fwd_live, fwd_rd_addr, fwd_data);
`else
    logic w_unused_fwd;

    assign w_in_fwd   = w_in_slot;
    assign w_main_fwd = r_main;
    assign w_skid_fwd = r_skid;

    // Without the bypass the writeback port and stored source fields have no reader.
    assign w_unused_fwd = ^{fwd_valid, fwd_rd_addr, fwd_data,
                            r_main.rs1, r_main.rs2, r_main.use_imm,
                            r_skid.rs1, r_skid.rs2, r_skid.use_imm};
`endif

    // Slot valid bits: flush empties both; otherwise fill/drain in op order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_consume) begin
            // A valid SKID implies in_ready=0, so no accept can coincide with the move.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Slot payloads: hold on flush, otherwise move ops and apply writeback bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (!r_main_valid || w_consume) begin
                if (r_skid_valid)
                    r_main <= w_skid_fwd;
                else if (w_accept)
                    r_main <= w_in_fwd;
                else
                    r_main <= w_main_fwd;
            end else begin
                r_main <= w_main_fwd;
                if (w_accept)
                    r_skid <= w_in_fwd;
                else
                    r_skid <= w_skid_fwd;
            end
        end
    end

    assign out_valid   = r_main_valid;
    assign alu_ctrl    = r_main.ctrl;
    assign alu_in_1    = r_main.op1;
    assign alu_in_2    = r_main.op2;
    assign out_rd_addr = r_main.rd;
    assign out_rd_we   = r_main.we;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage. The driver pushes the
//               expected ALU view of every accepted op; a monitor pops and
//               compares on each consume. Directed checks cover reset,
//               latency, backpressure, flush, immediates and bypass.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam logic [1:0] c_AND = 2'd0;
    localparam logic [1:0] c_OR  = 2'd1;
    localparam logic [1:0] c_ADD = 2'd2;
    localparam logic [1:0] c_SUB = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_addr;
    logic [31:0] fwd_data;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
        .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] alu_model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            c_AND:   return a & b;
            c_OR:    return a | b;
            c_ADD:   return a + b;
            default: return a - b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Offer one op and hold it until accepted; the expected view is queued on acceptance.
    task automatic send(input logic [1:0] c, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic ui, input logic [4:0] rd, input logic we, input logic [31:0] res);
        int   waited;
        bit   done;
        exp_t e;
        waited = 0;
        done   = 0;
        in_valid = 1'b1; in_ctrl = c; in_rs1_addr = a1; in_rs2_addr = a2;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = ui;
        in_rd_addr = rd; in_rd_we = we;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !flush && rst_n) begin
                e.ctrl = c; e.in1 = d1; e.in2 = ui ? imm : d2;
                e.res = res; e.rd = rd; e.we = we;
                sb.push_back(e);
                done = 1;
            end else if (++waited > 50) begin
                n_vec++; n_bad++;
                $display("FAIL send_timeout: got in_ready=0 for 50 cycles want accept");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every consume must match the oldest outstanding expected op.
    initial begin
        exp_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_op: got ctrl=%0d in1=0x%08h rd=%0d want no op", alu_ctrl, alu_in_1, out_rd_addr);
                end else begin
                    e = sb.pop_front();
                    r = alu_model(alu_ctrl, alu_in_1, alu_in_2);
                    if (alu_ctrl !== e.ctrl || alu_in_1 !== e.in1 || alu_in_2 !== e.in2 ||
                        r !== e.res || out_rd_addr !== e.rd || out_rd_we !== e.we) begin
                        n_bad++;
                        $display("FAIL op_compare: got ctrl=%0d in1=0x%08h in2=0x%08h res=0x%08h rd=%0d we=%0b want ctrl=%0d in1=0x%08h in2=0x%08h res=0x%08h rd=%0d we=%0b",
                                 alu_ctrl, alu_in_1, alu_in_2, r, out_rd_addr, out_rd_we,
                                 e.ctrl, e.in1, e.in2, e.res, e.rd, e.we);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] exp1;
        exp_t        e;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0;
        in_rd_addr = '0; in_rd_we = 1'b0;
        fwd_valid = 1'b0; fwd_rd_addr = '0; fwd_data = '0;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_alu_in_1",  alu_in_1, 32'd0);
        check("rst_alu_ctrl",  {30'd0, alu_ctrl}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at full rate, one-cycle latency
        out_ready = 1'b1;
        send(c_ADD, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 1'b0, 5'd3, 1'b1, 32'd7);
        check("lat_add_valid", {31'd0, out_valid}, 32'd1);
        send(c_SUB, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 1'b0, 5'd4, 1'b1, 32'd7);
        check("lat_sub_valid", {31'd0, out_valid}, 32'd1);
        check("stream_in_ready", {31'd0, in_ready}, 32'd1);
        send(c_AND, 5'd1, 5'd2, 32'hF0, 32'h3C, 32'd0, 1'b0, 5'd5, 1'b0, 32'h30);
        check("lat_and_valid", {31'd0, out_valid}, 32'd1);
        idle();
        cycles(3);
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Immediate operand selection
        send(c_OR, 5'd1, 5'd2, 32'h1, 32'd5, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b1, 32'hFFFFFFFD);
        check("imm_alu_in_2", alu_in_2, 32'hFFFFFFFC);
        idle();
        cycles(2);

        // Backpressure: fill MAIN and SKID, third op waits
        out_ready = 1'b0;
        send(c_ADD, 5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 1'b0, 5'd7, 1'b1, 32'h33);
        send(c_SUB, 5'd1, 5'd2, 32'd9, 32'd4, 32'd0, 1'b0, 5'd8, 1'b1, 32'd5);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(c_AND, 5'd1, 5'd2, 32'hFF, 32'h0F, 32'd0, 1'b0, 5'd9, 1'b1, 32'h0F);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_alu_in_1", alu_in_1, 32'h11);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle();
        cycles(4);
        check("bp_drained_valid", {31'd0, out_valid}, 32'd0);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Flush with both slots full and a new op offered
        out_ready = 1'b0;
        send(c_ADD, 5'd1, 5'd2, 32'h100, 32'h1, 32'd0, 1'b0, 5'd10, 1'b1, 32'h101);
        send(c_ADD, 5'd1, 5'd2, 32'h200, 32'h2, 32'd0, 1'b0, 5'd11, 1'b1, 32'h202);
        check("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_ctrl = c_SUB; in_rs1_data = 32'hDEAD; in_rs2_data = 32'h1;
        in_use_imm = 1'b0; in_rd_addr = 5'd12;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        idle();
        sb.delete();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_payload_hold", alu_in_1, 32'h100);
        out_ready = 1'b1;
        cycles(3);
        check("flush_no_op", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream with both slots full
        out_ready = 1'b0;
        send(c_ADD, 5'd1, 5'd2, 32'h55, 32'h1, 32'd0, 1'b0, 5'd13, 1'b1, 32'h56);
        send(c_ADD, 5'd1, 5'd2, 32'h66, 32'h1, 32'd0, 1'b0, 5'd14, 1'b1, 32'h67);
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_alu_in_1", alu_in_1, 32'd0);
        check("arst_alu_in_2", alu_in_2, 32'd0);
        check("arst_rd_addr", {27'd0, out_rd_addr}, 32'd0);
        check("arst_rd_we", {31'd0, out_rd_we}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        out_ready = 1'b1;
        send(c_SUB, 5'd1, 5'd2, 32'd20, 32'd8, 32'd0, 1'b0, 5'd15, 1'b1, 32'd12);
        idle();
        cycles(3);

        // Writeback bypass into a stalled op in MAIN
        out_ready = 1'b0;
        send(c_ADD, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 5'd7, 1'b1, 32'h33);
        idle();
        fwd_valid = 1'b1; fwd_rd_addr = 5'd5; fwd_data = 32'h1234;
        cycles(1);
        fwd_valid = 1'b0;
`ifdef FORWARD_EN
        exp1 = 32'h1234;
`else
        exp1 = 32'h11;
`endif
        check("fwd_x5_alu_in_1", alu_in_1, exp1);
        e = sb.pop_front();
        e.in1 = exp1;
`ifdef FORWARD_EN
        e.res = 32'h1256;
`else
        e.res = 32'h33;
`endif
        sb.push_front(e);
        fwd_valid = 1'b1; fwd_rd_addr = 5'd0; fwd_data = 32'hBEEF;
        cycles(1);
        fwd_valid = 1'b0;
        check("fwd_x0_alu_in_1", alu_in_1, exp1);
        check("fwd_x0_alu_in_2", alu_in_2, 32'h22);
        out_ready = 1'b1;
        cycles(3);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
